// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg
// Shared definitions for the 16-entry reorder buffer: instruction type codes,
// buffer geometry, controller states and the per-entry record.
// No ports (package).

package reorder_buffer_pkg;

  localparam int ROB_TAG_W = 4;
  localparam int ROB_DEPTH = 1 << ROB_TAG_W;

  typedef enum logic [1:0] {
    ROB_TYPE_NORMAL = 2'd0,
    ROB_TYPE_BRANCH = 2'd1,
    ROB_TYPE_JALR   = 2'd2,
    ROB_TYPE_STORE  = 2'd3
  } robType_e;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_FLUSH  = 1'b1
  } robState_e;

  typedef struct packed {
    logic        valid;
    logic        ready;
    robType_e    kind;
    logic [4:0]  dest;
    logic [31:0] pc;
    logic        predJump;
    logic [31:0] value;
  } robEntry_t;

  // Sequential fall-through PC of an instruction.
  function automatic logic [31:0] seqPc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/reorder_buffer_storage.sv
// reorder_buffer_storage
// Entry array of the reorder buffer: one allocation write port, two writeback
// ports, one free (retire) port, a bulk flush, and three read ports
// (head, q1, q2).
// Ports:
//   clk, rst                       clock / async active-high reset
//   i_flush                        invalidate every entry
//   i_allocEn/Idx/Entry            write a complete new entry
//   i_wb0En/Idx/Value, i_wb1*      set ready+value of a valid entry (wb0 wins)
//   i_freeEn/Idx                   invalidate a retired entry
//   i_headIdx -> o_headEntry       full record at head
//   i_q1Idx/i_q2Idx -> o_q*Valid/Ready/Value   operand queries

module reorder_buffer_storage
  import reorder_buffer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_flush,
  input  logic                 i_allocEn,
  input  logic [ROB_TAG_W-1:0] i_allocIdx,
  input  robEntry_t            i_allocEntry,
  input  logic                 i_wb0En,
  input  logic [ROB_TAG_W-1:0] i_wb0Idx,
  input  logic [31:0]          i_wb0Value,
  input  logic                 i_wb1En,
  input  logic [ROB_TAG_W-1:0] i_wb1Idx,
  input  logic [31:0]          i_wb1Value,
  input  logic                 i_freeEn,
  input  logic [ROB_TAG_W-1:0] i_freeIdx,
  input  logic [ROB_TAG_W-1:0] i_headIdx,
  output robEntry_t            o_headEntry,
  input  logic [ROB_TAG_W-1:0] i_q1Idx,
  output logic                 o_q1Valid,
  output logic                 o_q1Ready,
  output logic [31:0]          o_q1Value,
  input  logic [ROB_TAG_W-1:0] i_q2Idx,
  output logic                 o_q2Valid,
  output logic                 o_q2Ready,
  output logic [31:0]          o_q2Value
);

  robEntry_t r_entries [ROB_DEPTH];

  // wb1 is applied before wb0 so that wb0 wins on a shared tag. The valid
  // test uses pre-edge state, so a writeback can never hit the entry being
  // allocated in the same edge (the tail slot is always invalid).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROB_DEPTH; i++) r_entries[i] <= '0;
    end else if (i_flush) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        r_entries[i].valid <= 1'b0;
        r_entries[i].ready <= 1'b0;
      end
    end else begin
      if (i_allocEn) r_entries[i_allocIdx] <= i_allocEntry;
      if (i_wb1En && r_entries[i_wb1Idx].valid) begin
        r_entries[i_wb1Idx].ready <= 1'b1;
        r_entries[i_wb1Idx].value <= i_wb1Value;
      end
      if (i_wb0En && r_entries[i_wb0Idx].valid) begin
        r_entries[i_wb0Idx].ready <= 1'b1;
        r_entries[i_wb0Idx].value <= i_wb0Value;
      end
      if (i_freeEn) begin
        r_entries[i_freeIdx].valid <= 1'b0;
        r_entries[i_freeIdx].ready <= 1'b0;
      end
    end
  end

  assign o_headEntry = r_entries[i_headIdx];
  assign o_q1Valid   = r_entries[i_q1Idx].valid;
  assign o_q1Ready   = r_entries[i_q1Idx].ready;
  assign o_q1Value   = r_entries[i_q1Idx].value;
  assign o_q2Valid   = r_entries[i_q2Idx].valid;
  assign o_q2Ready   = r_entries[i_q2Idx].ready;
  assign o_q2Value   = r_entries[i_q2Idx].value;

endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer
// 16-entry circular reorder buffer. Allocates a rename tag per issued
// instruction, captures results from two writeback ports, retires in order
// onto a registered commit bus, and sequences a one-cycle flush when a
// committed branch turns out mispredicted.
// Optional build macro: ROB_BYPASS_EN - operand queries also forward the
// same-cycle wb0/wb1 results (wb0 priority).
// Ports:
//   clk, rst, i_rdy                            clock, async reset, global hold
//   i_issue_*  / o_alloc_rename, o_rob_full    allocation
//   i_wb0_*, i_wb1_*                           writeback (ALU / LSB)
//   i_q1/q2_rename -> o_q1/q2_ready/value      operand queries
//   o_commit_*, o_jalr_next_pc, o_store_commit commit bus (registered)
//   o_cdb_flush, o_flush_pc                    flush pulse and redirect PC

module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_rdy,
  input  logic             i_issue_valid,
  input  logic [1:0]       i_issue_type,
  input  logic [4:0]       i_issue_dest,
  input  logic [31:0]      i_issue_pc,
  input  logic             i_issue_pred_jump,
  input  logic             i_issue_ready,
  input  logic [31:0]      i_issue_value,
  output logic [TAG_W-1:0] o_alloc_rename,
  output logic             o_rob_full,
  input  logic             i_wb0_valid,
  input  logic [TAG_W-1:0] i_wb0_rename,
  input  logic [31:0]      i_wb0_value,
  input  logic             i_wb1_valid,
  input  logic [TAG_W-1:0] i_wb1_rename,
  input  logic [31:0]      i_wb1_value,
  input  logic [TAG_W-1:0] i_q1_rename,
  input  logic [TAG_W-1:0] i_q2_rename,
  output logic             o_q1_ready,
  output logic [31:0]      o_q1_value,
  output logic             o_q2_ready,
  output logic [31:0]      o_q2_value,
  output logic             o_commit_flag,
  output logic [31:0]      o_commit_value,
  output logic [TAG_W-1:0] o_commit_rename,
  output logic [4:0]       o_commit_dest,
  output logic             o_commit_is_branch,
  output logic             o_commit_is_jalr,
  output logic [31:0]      o_jalr_next_pc,
  output logic             o_store_commit,
  output logic             o_cdb_flush,
  output logic [31:0]      o_flush_pc
);

  robState_e        r_state;
  logic [TAG_W-1:0] r_head, r_tail;
  logic [TAG_W:0]   r_count;
  logic             r_commitFlag, r_commitIsBranch, r_commitIsJalr;
  logic             r_storeCommit, r_cdbFlush;
  logic [31:0]      r_commitValue, r_jalrNextPc, r_flushPc;
  logic [TAG_W-1:0] r_commitRename;
  logic [4:0]       r_commitDest;

  logic      w_full, w_alloc, w_wbEn, w_commit, w_mispredict, w_flushNow;
  robEntry_t w_allocEntry, w_headEntry;
  logic      w_q1Valid, w_q1Ready, w_q2Valid, w_q2Ready;
  logic [31:0] w_q1Value, w_q2Value;

  assign w_full     = (r_count == 5'd16);
  assign w_wbEn     = i_rdy && (r_state == ST_NORMAL);
  assign w_alloc    = w_wbEn && i_issue_valid && !w_full;
  assign w_commit   = w_wbEn && w_headEntry.valid && w_headEntry.ready;
  assign w_flushNow = i_rdy && (r_state == ST_FLUSH);
  assign w_mispredict = w_commit && (w_headEntry.kind == ROB_TYPE_BRANCH)
                        && (w_headEntry.value[0] != w_headEntry.predJump);

  always_comb begin
    w_allocEntry          = '0;
    w_allocEntry.valid    = 1'b1;
    w_allocEntry.ready    = i_issue_ready;
    w_allocEntry.kind     = robType_e'(i_issue_type);
    w_allocEntry.dest     = i_issue_dest;
    w_allocEntry.pc       = i_issue_pc;
    w_allocEntry.predJump = i_issue_pred_jump;
    w_allocEntry.value    = i_issue_ready ? i_issue_value : 32'd0;
  end

  reorder_buffer_storage u_storage (
    .clk          (clk),
    .rst          (rst),
    .i_flush      (w_flushNow),
    .i_allocEn    (w_alloc),
    .i_allocIdx   (r_tail),
    .i_allocEntry (w_allocEntry),
    .i_wb0En      (w_wbEn && i_wb0_valid),
    .i_wb0Idx     (i_wb0_rename),
    .i_wb0Value   (i_wb0_value),
    .i_wb1En      (w_wbEn && i_wb1_valid),
    .i_wb1Idx     (i_wb1_rename),
    .i_wb1Value   (i_wb1_value),
    .i_freeEn     (w_commit),
    .i_freeIdx    (r_head),
    .i_headIdx    (r_head),
    .o_headEntry  (w_headEntry),
    .i_q1Idx      (i_q1_rename),
    .o_q1Valid    (w_q1Valid),
    .o_q1Ready    (w_q1Ready),
    .o_q1Value    (w_q1Value),
    .i_q2Idx      (i_q2_rename),
    .o_q2Valid    (w_q2Valid),
    .o_q2Ready    (w_q2Ready),
    .o_q2Value    (w_q2Value)
  );

  // Operand queries; with bypass, a writeback landing on a valid entry this
  // cycle is visible before it is stored.
  always_comb begin
    o_q1_ready = w_q1Valid && w_q1Ready;
    o_q1_value = w_q1Value;
    o_q2_ready = w_q2Valid && w_q2Ready;
    o_q2_value = w_q2Value;
`ifdef ROB_BYPASS_EN
    if (w_wbEn && w_q1Valid) begin
      if (i_wb0_valid && (i_wb0_rename == i_q1_rename)) begin
        o_q1_ready = 1'b1;
        o_q1_value = i_wb0_value;
      end else if (i_wb1_valid && (i_wb1_rename == i_q1_rename)) begin
        o_q1_ready = 1'b1;
        o_q1_value = i_wb1_value;
      end
    end
    if (w_wbEn && w_q2Valid) begin
      if (i_wb0_valid && (i_wb0_rename == i_q2_rename)) begin
        o_q2_ready = 1'b1;
        o_q2_value = i_wb0_value;
      end else if (i_wb1_valid && (i_wb1_rename == i_q2_rename)) begin
        o_q2_ready = 1'b1;
        o_q2_value = i_wb1_value;
      end
    end
`endif
  end

  // Controller. Pulses (commit, store, flush) default low every edge so they
  // also drop while rdy is low; the other commit fields hold. The flush PC is
  // latched at the mispredicted commit and the pulse follows one cycle later
  // from the FLUSH state, which also empties the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= ST_NORMAL;
      r_head           <= '0;
      r_tail           <= '0;
      r_count          <= '0;
      r_commitFlag     <= 1'b0;
      r_commitValue    <= '0;
      r_commitRename   <= '0;
      r_commitDest     <= '0;
      r_commitIsBranch <= 1'b0;
      r_commitIsJalr   <= 1'b0;
      r_jalrNextPc     <= '0;
      r_storeCommit    <= 1'b0;
      r_cdbFlush       <= 1'b0;
      r_flushPc        <= '0;
    end else begin
      r_commitFlag  <= 1'b0;
      r_storeCommit <= 1'b0;
      r_cdbFlush    <= 1'b0;
      if (i_rdy) begin
        case (r_state)
          ST_NORMAL: begin
            if (w_alloc) r_tail <= r_tail + 1'b1;
            r_count <= r_count + 5'(w_alloc) - 5'(w_commit);
            if (w_commit) begin
              r_head           <= r_head + 1'b1;
              r_commitFlag     <= 1'b1;
              r_commitValue    <= w_headEntry.value;
              r_commitRename   <= r_head;
              r_commitDest     <= w_headEntry.dest;
              r_commitIsBranch <= (w_headEntry.kind == ROB_TYPE_BRANCH);
              r_commitIsJalr   <= (w_headEntry.kind == ROB_TYPE_JALR);
              r_jalrNextPc     <= seqPc(w_headEntry.pc);
              r_storeCommit    <= (w_headEntry.kind == ROB_TYPE_STORE);
            end
            if (w_mispredict) begin
              r_state   <= ST_FLUSH;
              r_flushPc <= w_headEntry.value[0] ? {w_headEntry.value[31:1], 1'b0}
                                                : seqPc(w_headEntry.pc);
            end
          end
          ST_FLUSH: begin
            r_cdbFlush <= 1'b1;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_state    <= ST_NORMAL;
          end
          default: r_state <= ST_NORMAL;
        endcase
      end
    end
  end

  assign o_alloc_rename     = r_tail;
  assign o_rob_full         = w_full;
  assign o_commit_flag      = r_commitFlag;
  assign o_commit_value     = r_commitValue;
  assign o_commit_rename    = r_commitRename;
  assign o_commit_dest      = r_commitDest;
  assign o_commit_is_branch = r_commitIsBranch;
  assign o_commit_is_jalr   = r_commitIsJalr;
  assign o_jalr_next_pc     = r_jalrNextPc;
  assign o_store_commit     = r_storeCommit;
  assign o_cdb_flush        = r_cdbFlush;
  assign o_flush_pc         = r_flushPc;

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer
// Directed bench for reorder_buffer: fill/full/wrap, out-of-order writeback
// with in-order commit, store commit, not-taken and taken mispredict flushes,
// jalr commit, dual writeback priority, invalid writeback, rdy hold.

module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        issueValid = 1'b0;
  logic [1:0]  issueType = 2'd0;
  logic [4:0]  issueDest = 5'd0;
  logic [31:0] issuePc = 32'd0;
  logic        issuePredJump = 1'b0;
  logic        issueReady = 1'b0;
  logic [31:0] issueValue = 32'd0;
  logic        wb0Valid = 1'b0, wb1Valid = 1'b0;
  logic [3:0]  wb0Rename = 4'd0, wb1Rename = 4'd0;
  logic [31:0] wb0Value = 32'd0, wb1Value = 32'd0;
  logic [3:0]  q1Rename = 4'd0, q2Rename = 4'd0;

  logic [3:0]  allocRename, commitRename;
  logic        robFull, q1Ready, q2Ready;
  logic [31:0] q1Value, q2Value, commitValue, jalrNextPc, flushPc;
  logic        commitFlag, commitIsBranch, commitIsJalr, storeCommit, cdbFlush;
  logic [4:0]  commitDest;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reorder_buffer #(.TAG_W(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .i_rdy              (rdy),
    .i_issue_valid      (issueValid),
    .i_issue_type       (issueType),
    .i_issue_dest       (issueDest),
    .i_issue_pc         (issuePc),
    .i_issue_pred_jump  (issuePredJump),
    .i_issue_ready      (issueReady),
    .i_issue_value      (issueValue),
    .o_alloc_rename     (allocRename),
    .o_rob_full         (robFull),
    .i_wb0_valid        (wb0Valid),
    .i_wb0_rename       (wb0Rename),
    .i_wb0_value        (wb0Value),
    .i_wb1_valid        (wb1Valid),
    .i_wb1_rename       (wb1Rename),
    .i_wb1_value        (wb1Value),
    .i_q1_rename        (q1Rename),
    .i_q2_rename        (q2Rename),
    .o_q1_ready         (q1Ready),
    .o_q1_value         (q1Value),
    .o_q2_ready         (q2Ready),
    .o_q2_value         (q2Value),
    .o_commit_flag      (commitFlag),
    .o_commit_value     (commitValue),
    .o_commit_rename    (commitRename),
    .o_commit_dest      (commitDest),
    .o_commit_is_branch (commitIsBranch),
    .o_commit_is_jalr   (commitIsJalr),
    .o_jalr_next_pc     (jalrNextPc),
    .o_store_commit     (storeCommit),
    .o_cdb_flush        (cdbFlush),
    .o_flush_pc         (flushPc)
  );

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic issueOp(input logic [1:0] kind, input logic [4:0] dest,
                         input logic [31:0] pc, input logic pred,
                         input logic ready, input logic [31:0] value);
    issueValid = 1'b1; issueType = kind; issueDest = dest; issuePc = pc;
    issuePredJump = pred; issueReady = ready; issueValue = value;
    applyStimulus();
    issueValid = 1'b0; issueReady = 1'b0;
  endtask

  task automatic writeBack0(input logic [3:0] tag, input logic [31:0] value);
    wb0Valid = 1'b1; wb0Rename = tag; wb0Value = value;
    applyStimulus();
    wb0Valid = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_commit_flag", 32'(commitFlag), 32'd0);
    checkOutput("rst_cdb_flush", 32'(cdbFlush), 32'd0);
    checkOutput("rst_flush_pc", flushPc, 32'd0);
    checkOutput("rst_alloc_rename", 32'(allocRename), 32'd0);
    checkOutput("rst_rob_full", 32'(robFull), 32'd0);
    rst = 1'b0;
    applyStimulus();

    // Fill all 16 entries, then a 17th issue must be ignored
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("fill_tag_%0d", i), 32'(allocRename), 32'(i));
      issueOp(2'd0, 5'(i + 1), 32'h1000 + 32'(i * 4), 1'b0, 1'b0, 32'd0);
    end
    checkOutput("full_flag", 32'(robFull), 32'd1);
    issueOp(2'd0, 5'd9, 32'h2000, 1'b0, 1'b0, 32'd0);
    checkOutput("full_blocks_tail", 32'(allocRename), 32'd0);
    checkOutput("full_flag_held", 32'(robFull), 32'd1);

    // Drain: write each tag in order; each commits on the following edge
    for (int k = 0; k < 16; k++) begin
      wb0Valid = 1'b1; wb0Rename = 4'(k); wb0Value = 32'h100 + 32'(k);
      applyStimulus();
      if (k == 0) begin
        checkOutput("drain_no_commit_yet", 32'(commitFlag), 32'd0);
      end else begin
        checkOutput($sformatf("drain_flag_%0d", k - 1), 32'(commitFlag), 32'd1);
        checkOutput($sformatf("drain_tag_%0d", k - 1), 32'(commitRename), 32'(k - 1));
        checkOutput($sformatf("drain_val_%0d", k - 1), commitValue, 32'h100 + 32'(k - 1));
      end
    end
    wb0Valid = 1'b0;
    applyStimulus();
    checkOutput("drain_tag_15", 32'(commitRename), 32'd15);
    checkOutput("drain_dest_15", 32'(commitDest), 32'd16);
    applyStimulus();
    checkOutput("drain_done_flag", 32'(commitFlag), 32'd0);
    checkOutput("drain_not_full", 32'(robFull), 32'd0);
    checkOutput("wrap_tail", 32'(allocRename), 32'd0);

    // Out-of-order writeback, in-order commit
    issueOp(2'd0, 5'd5, 32'h10, 1'b0, 1'b0, 32'd0);
    issueOp(2'd0, 5'd6, 32'h14, 1'b0, 1'b0, 32'd0);
    writeBack0(4'd1, 32'h22);
    checkOutput("ooo_tag1_no_commit", 32'(commitFlag), 32'd0);
    writeBack0(4'd0, 32'h11);
    checkOutput("ooo_latency", 32'(commitFlag), 32'd0);
    applyStimulus();
    checkOutput("ooo_c0_flag", 32'(commitFlag), 32'd1);
    checkOutput("ooo_c0_tag", 32'(commitRename), 32'd0);
    checkOutput("ooo_c0_val", commitValue, 32'h11);
    checkOutput("ooo_c0_dest", 32'(commitDest), 32'd5);
    applyStimulus();
    checkOutput("ooo_c1_flag", 32'(commitFlag), 32'd1);
    checkOutput("ooo_c1_tag", 32'(commitRename), 32'd1);
    checkOutput("ooo_c1_val", commitValue, 32'h22);

    // Store ready at issue commits on the next edge
    issueOp(2'd3, 5'd0, 32'h18, 1'b0, 1'b1, 32'd0);
    checkOutput("st_flag_low", 32'(commitFlag), 32'd0);
    applyStimulus();
    checkOutput("st_commit", 32'(storeCommit), 32'd1);
    checkOutput("st_tag", 32'(commitRename), 32'd2);

    // Not-taken mispredict (predicted taken)
    checkOutput("br_tag", 32'(allocRename), 32'd3);
    issueOp(2'd1, 5'd0, 32'h100, 1'b1, 1'b0, 32'd0);
    checkOutput("st_pulse_end", 32'(storeCommit), 32'd0);
    writeBack0(4'd3, 32'd0);
    applyStimulus();
    checkOutput("br_commit_flag", 32'(commitFlag), 32'd1);
    checkOutput("br_is_branch", 32'(commitIsBranch), 32'd1);
    checkOutput("br_no_flush_yet", 32'(cdbFlush), 32'd0);
    applyStimulus();
    checkOutput("br_flush", 32'(cdbFlush), 32'd1);
    checkOutput("br_flush_pc", flushPc, 32'h104);
    checkOutput("br_alloc_zero", 32'(allocRename), 32'd0);
    applyStimulus();
    checkOutput("br_flush_pulse_end", 32'(cdbFlush), 32'd0);

    // jalr commit
    issueOp(2'd2, 5'd1, 32'h200, 1'b0, 1'b0, 32'd0);
    writeBack0(4'd0, 32'h300);
    applyStimulus();
    checkOutput("jalr_flag", 32'(commitIsJalr), 32'd1);
    checkOutput("jalr_value", commitValue, 32'h300);
    checkOutput("jalr_next_pc", jalrNextPc, 32'h204);
    checkOutput("jalr_not_branch", 32'(commitIsBranch), 32'd0);

    // Taken mispredict: target comes from the branch writeback value
    issueOp(2'd1, 5'd0, 32'h140, 1'b0, 1'b0, 32'd0);
    writeBack0(4'd1, 32'h181);
    applyStimulus();
    checkOutput("tk_commit_tag", 32'(commitRename), 32'd1);
    applyStimulus();
    checkOutput("tk_flush", 32'(cdbFlush), 32'd1);
    checkOutput("tk_flush_pc", flushPc, 32'h180);
    applyStimulus();

    // Dual writeback to tag 3: wb0 wins
    for (int i = 0; i < 4; i++) issueOp(2'd0, 5'(i + 2), 32'h400, 1'b0, 1'b0, 32'd0);
    wb0Valid = 1'b1; wb0Rename = 4'd3; wb0Value = 32'd5;
    wb1Valid = 1'b1; wb1Rename = 4'd3; wb1Value = 32'd9;
    q1Rename = 4'd3;
    #1;
`ifdef ROB_BYPASS_EN
    checkOutput("byp_q1_ready", 32'(q1Ready), 32'd1);
    checkOutput("byp_q1_value", q1Value, 32'd5);
`else
    checkOutput("nobyp_q1_ready", 32'(q1Ready), 32'd0);
`endif
    applyStimulus();
    wb0Valid = 1'b0; wb1Valid = 1'b0;
    q2Rename = 4'd3;
    #1;
    checkOutput("dual_q1_ready", 32'(q1Ready), 32'd1);
    checkOutput("dual_q1_value", q1Value, 32'd5);
    checkOutput("dual_q2_value", q2Value, 32'd5);

    // Writeback to an unallocated entry is dropped
    writeBack0(4'd7, 32'h77);
    q2Rename = 4'd7;
    #1;
    checkOutput("inv_wb_q2_ready", 32'(q2Ready), 32'd0);

    // rdy low holds everything; issue also blocked
    writeBack0(4'd0, 32'h44);
    rdy = 1'b0;
    issueValid = 1'b1; issueType = 2'd0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput($sformatf("hold_flag_%0d", i), 32'(commitFlag), 32'd0);
      checkOutput($sformatf("hold_tail_%0d", i), 32'(allocRename), 32'd4);
      checkOutput($sformatf("hold_value_%0d", i), commitValue, 32'h181);
    end
    issueValid = 1'b0;
    rdy = 1'b1;
    applyStimulus();
    checkOutput("resume_flag", 32'(commitFlag), 32'd1);
    checkOutput("resume_tag", 32'(commitRename), 32'd0);
    checkOutput("resume_value", commitValue, 32'h44);
    checkOutput("resume_tail", 32'(allocRename), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
